// File: rtl/mips_mem_arbiter_if.sv
// Bus bundle for mips_mem_arbiter: CPU and loader request channels plus the memory port.
// The arbiter takes the slave view; requesters and the memory macro sit on the master view.
interface mips_mem_arbiter_if #(
   parameter int AW = 10,
   parameter int DW = 32
);
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_gnt;
   logic          cpu_rvalid;
   logic [DW-1:0] cpu_rdata;

   logic          ldr_req;
   logic          ldr_we;
   logic [AW-1:0] ldr_addr;
   logic [DW-1:0] ldr_wdata;
   logic          ldr_gnt;
   logic          ldr_rvalid;
   logic [DW-1:0] ldr_rdata;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   logic          owner;
   logic          busy;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_gnt, cpu_rvalid, cpu_rdata,
      output ldr_req, ldr_we, ldr_addr, ldr_wdata,
      input  ldr_gnt, ldr_rvalid, ldr_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata,
      input  owner, busy
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_gnt, cpu_rvalid, cpu_rdata,
      input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
      output ldr_gnt, ldr_rvalid, ldr_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata,
      output owner, busy
   );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Two-requester (CPU / loader) arbiter in front of a single-port memory, one access in flight.
// Define MIPS_MEM_ARB_RR_EN for round-robin tie-break; otherwise the CPU has fixed priority.
module mips_mem_arbiter #(
   parameter int AW     = 10,
   parameter int DW     = 32,
   parameter int RD_LAT = 1
) (
   input logic               clk,
   input logic               rst,
   mips_mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

   localparam logic [1:0] LAT_INIT = 2'(RD_LAT);

   state_e        state_q,      state_d;
   logic [1:0]    lat_cnt_q,    lat_cnt_d;
   logic          owner_q,      owner_d;
   logic          mem_en_q,     mem_en_d;
   logic          mem_we_q,     mem_we_d;
   logic [AW-1:0] mem_addr_q,   mem_addr_d;
   logic [DW-1:0] mem_wdata_q,  mem_wdata_d;
   logic          busy_q,       busy_d;
   logic          cpu_rvalid_q, cpu_rvalid_d;
   logic          ldr_rvalid_q, ldr_rvalid_d;

   logic          win_ldr_s;
   logic          cpu_gnt_s;
   logic          ldr_gnt_s;

   // Winner selection among pending requests
   always_comb begin
      win_ldr_s = 1'b0;
      if (bus.cpu_req && bus.ldr_req) begin
`ifdef MIPS_MEM_ARB_RR_EN
         win_ldr_s = ~owner_q;
`else
         win_ldr_s = 1'b0;
`endif
      end else if (bus.ldr_req) begin
         win_ldr_s = 1'b1;
      end else begin
         win_ldr_s = 1'b0;
      end
   end

   // Next-state, payload capture and output decode
   always_comb begin
      state_d     = state_q;
      lat_cnt_d   = lat_cnt_q;
      owner_d     = owner_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_gnt_s   = 1'b0;
      ldr_gnt_s   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Grant is suppressed while reset is held so nothing is accepted then
            if (!rst && (bus.cpu_req || bus.ldr_req)) begin
               cpu_gnt_s = ~win_ldr_s;
               ldr_gnt_s = win_ldr_s;
               owner_d   = win_ldr_s;
               if (win_ldr_s) begin
                  mem_we_d    = bus.ldr_we;
                  mem_addr_d  = bus.ldr_addr;
                  mem_wdata_d = bus.ldr_wdata;
               end else begin
                  mem_we_d    = bus.cpu_we;
                  mem_addr_d  = bus.cpu_addr;
                  mem_wdata_d = bus.cpu_wdata;
               end
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (mem_we_q) begin
               state_d = ST_IDLE;
            end else begin
               lat_cnt_d = LAT_INIT;
               state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            lat_cnt_d = lat_cnt_q - 2'd1;
            if (lat_cnt_q == 2'd1) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            lat_cnt_d = 2'd0;
         end
      endcase

      mem_en_d     = (state_d == ST_ISSUE);
      busy_d       = (state_d != ST_IDLE);
      cpu_rvalid_d = (state_d == ST_WAIT) && (lat_cnt_d == 2'd1) && !owner_d;
      ldr_rvalid_d = (state_d == ST_WAIT) && (lat_cnt_d == 2'd1) &&  owner_d;
   end

   // State and registered outputs, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         lat_cnt_q    <= 2'd0;
         owner_q      <= 1'b1;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= {AW{1'b0}};
         mem_wdata_q  <= {DW{1'b0}};
         busy_q       <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         ldr_rvalid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         lat_cnt_q    <= lat_cnt_d;
         owner_q      <= owner_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         busy_q       <= busy_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         ldr_rvalid_q <= ldr_rvalid_d;
      end
   end

   assign bus.cpu_gnt    = cpu_gnt_s;
   assign bus.ldr_gnt    = ldr_gnt_s;
   assign bus.cpu_rvalid = cpu_rvalid_q;
   assign bus.ldr_rvalid = ldr_rvalid_q;
   assign bus.cpu_rdata  = bus.mem_rdata;
   assign bus.ldr_rdata  = bus.mem_rdata;
   assign bus.mem_en     = mem_en_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.owner      = owner_q;
   assign bus.busy       = busy_q;

endmodule
